// File: rtl/usb4_ll_pkg.sv
// Shared types and constants for the USB4 logical layer.
// Optional scrambler is built only with USB4_SCRAMBLER_EN defined.
package usb4_ll_pkg;

    typedef enum logic [1:0] {
        ST_CLD      = 2'd0,
        ST_TRAINING = 2'd1,
        ST_CL0      = 2'd2
    } ll_state_e;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h04;
    localparam logic [7:0] ADDR_RX_COUNT = 8'h08;
    localparam logic [7:0] ADDR_SCRATCH  = 8'h0C;

    localparam logic [7:0] TS_SYMBOL_DEF = 8'h4B;

    // x^16 + x^5 + x^4 + x^3 + 1, Galois form (x^16 implied)
    localparam logic [15:0] LFSR_POLY = 16'h0039;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;

    function automatic logic [15:0] lfsr_step8(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            if (r[15]) r = {r[14:0], 1'b0} ^ LFSR_POLY;
            else       r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

endpackage

// File: rtl/usb4_ll_scrambler.sv
// Byte-wide LFSR keystream generator with seed load and 8-bit advance.
// Keystream byte is the low byte of the current LFSR state.
module usb4_ll_scrambler
    import usb4_ll_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_load,
    input  logic       advance,
    output logic [7:0] keystream
);

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= '0;
        end else if (seed_load) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= lfsr_step8(lfsr);
        end
    end

    assign keystream = lfsr[7:0];

endmodule

// File: rtl/usb4_logical_layer.sv
// USB4 logical layer: config regs, sideband, CLD/TRAINING/CL0 link FSM.
// Define USB4_SCRAMBLER_EN to enable the TX/RX scrambler.
module usb4_logical_layer
    import usb4_ll_pkg::*;
#(
    parameter int         SBRX_FILTER   = 4,
    parameter int         TS_COUNT      = 8,
    parameter int         TRAIN_TIMEOUT = 1024,
    parameter logic [7:0] TS_SYMBOL     = TS_SYMBOL_DEF
) (
    input  logic        local_clk,
    input  logic        rst,
    input  logic        lane_disable,
    input  logic        c_read,
    input  logic        c_write,
    input  logic [7:0]  c_address,
    input  logic [31:0] c_data_in,
    output logic [31:0] c_data_out,
    input  logic [7:0]  transport_layer_data_in,
    output logic [7:0]  transport_layer_data_out,
    input  logic [7:0]  lane_0_rx_i,
    input  logic [7:0]  lane_1_rx_i,
    input  logic        data_incoming,
    input  logic        sbrx,
    output logic        sbtx,
    output logic [7:0]  lane_0_tx_o,
    output logic [7:0]  lane_1_tx_o,
    output logic        enable_scr
);

    localparam int SBW = $clog2(SBRX_FILTER + 1);
    localparam int TSW = $clog2(TS_COUNT + 1);
    localparam int TMW = $clog2(TRAIN_TIMEOUT + 1);

    ll_state_e   state, state_nx;
    logic        link_en, scr_en, train_to;
    logic [31:0] rx_count, scratch, rdata;
    logic [SBW-1:0] sb_cnt;
    logic [TSW-1:0] ts_cnt;
    logic [TMW-1:0] timer;
    logic        link_ok, sb_ready, ts_hit, ts_done, tmo, to_set;
    logic        rx_take, to_clr;
    logic [7:0]  tx_q, rx_q, tx_ks, rx_ks, lane_tx;

    // Lane 1 is observed only; it drives no state.
    logic lane_1_unused;
    assign lane_1_unused = ^lane_1_rx_i;

    assign link_ok  = link_en & ~lane_disable & sbrx;
    assign sb_ready = sb_cnt == SBW'(SBRX_FILTER - 1);
    assign ts_hit   = data_incoming & (lane_0_rx_i == TS_SYMBOL);
    assign ts_done  = ts_hit & (ts_cnt == TSW'(TS_COUNT - 1));
    assign tmo      = timer == TMW'(TRAIN_TIMEOUT - 1);
    assign rx_take  = (state == ST_CL0) & data_incoming;

`ifdef USB4_SCRAMBLER_EN
    assign enable_scr = (state == ST_CL0) & scr_en;
`else
    assign enable_scr = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        to_set   = 1'b0;
        unique case (state)
            ST_CLD: begin
                if (link_ok && sb_ready) state_nx = ST_TRAINING;
            end
            ST_TRAINING: begin
                if (!link_ok) begin
                    state_nx = ST_CLD;
                end else if (ts_done) begin
                    state_nx = ST_CL0;
                end else if (tmo) begin
                    state_nx = ST_CLD;
                    to_set   = 1'b1;
                end
            end
            ST_CL0: begin
                if (!link_ok) state_nx = ST_CLD;
            end
            default: state_nx = ST_CLD;
        endcase
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_CLD;
            sb_cnt <= '0;
            ts_cnt <= '0;
            timer  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_CLD && link_ok && !sb_ready) sb_cnt <= sb_cnt + 1'b1;
            else                                          sb_cnt <= '0;
            if (state == ST_TRAINING && ts_hit && !ts_done) ts_cnt <= ts_cnt + 1'b1;
            else                                             ts_cnt <= '0;
            if (state == ST_TRAINING && !tmo) timer <= timer + 1'b1;
            else                              timer <= '0;
        end
    end

    assign to_clr = c_write & (c_address == ADDR_STATUS) & c_data_in[2];

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            link_en  <= 1'b0;
            scr_en   <= 1'b0;
            scratch  <= '0;
            train_to <= 1'b0;
        end else begin
            if (c_write && c_address == ADDR_CTRL) begin
                link_en <= c_data_in[0];
                scr_en  <= c_data_in[1];
            end
            if (c_write && c_address == ADDR_SCRATCH) scratch <= c_data_in;
            // A timeout in the same cycle as a clear wins
            train_to <= to_set | (train_to & ~to_clr);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            c_address == ADDR_CTRL:     rdata = {30'd0, scr_en, link_en};
            c_address == ADDR_STATUS:   rdata = {29'd0, train_to, state};
            c_address == ADDR_RX_COUNT: rdata = rx_count;
            c_address == ADDR_SCRATCH:  rdata = scratch;
            default:                    rdata = '0;
        endcase
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            c_data_out <= '0;
        end else if (c_read) begin
            c_data_out <= rdata;
        end
    end

    usb4_ll_scrambler u_tx_scr (
        .clk       (local_clk),
        .rst       (rst),
        .seed_load (state != ST_CL0),
        .advance   (enable_scr),
        .keystream (tx_ks)
    );

    usb4_ll_scrambler u_rx_scr (
        .clk       (local_clk),
        .rst       (rst),
        .seed_load (state != ST_CL0),
        .advance   (enable_scr & data_incoming),
        .keystream (rx_ks)
    );

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            tx_q     <= '0;
            rx_q     <= '0;
            rx_count <= '0;
        end else begin
            tx_q <= transport_layer_data_in ^ (enable_scr ? tx_ks : 8'h00);
            if (rx_take) begin
                rx_q     <= lane_0_rx_i ^ (enable_scr ? rx_ks : 8'h00);
                rx_count <= rx_count + 32'd1;
            end
        end
    end

    always_comb begin
        lane_tx = 8'h00;
        unique case (1'b1)
            state == ST_CL0:      lane_tx = tx_q;
            state == ST_TRAINING: lane_tx = TS_SYMBOL;
            default:              lane_tx = 8'h00;
        endcase
    end

    assign lane_0_tx_o = lane_tx;
    assign lane_1_tx_o = lane_tx;
    assign sbtx = (state == ST_CLD) ? (link_en & ~lane_disable) : 1'b1;
    assign transport_layer_data_out = rx_q;

endmodule

// File: tb/tb_usb4_logical_layer.sv
// Directed self-checking bench for usb4_logical_layer.
// Scrambled-TX expectations follow USB4_SCRAMBLER_EN when defined.
module tb_usb4_logical_layer;

    logic        local_clk = 1'b0;
    logic        rst = 1'b0;
    logic        lane_disable = 1'b0;
    logic        c_read = 1'b0;
    logic        c_write = 1'b0;
    logic [7:0]  c_address = '0;
    logic [31:0] c_data_in = '0;
    logic [31:0] c_data_out;
    logic [7:0]  transport_layer_data_in = '0;
    logic [7:0]  transport_layer_data_out;
    logic [7:0]  lane_0_rx_i = '0;
    logic [7:0]  lane_1_rx_i = '0;
    logic        data_incoming = 1'b0;
    logic        sbrx = 1'b0;
    logic        sbtx;
    logic [7:0]  lane_0_tx_o;
    logic [7:0]  lane_1_tx_o;
    logic        enable_scr;

    int checks = 0;
    int errors = 0;

    usb4_logical_layer dut (
        .local_clk                (local_clk),
        .rst                      (rst),
        .lane_disable             (lane_disable),
        .c_read                   (c_read),
        .c_write                  (c_write),
        .c_address                (c_address),
        .c_data_in                (c_data_in),
        .c_data_out               (c_data_out),
        .transport_layer_data_in  (transport_layer_data_in),
        .transport_layer_data_out (transport_layer_data_out),
        .lane_0_rx_i              (lane_0_rx_i),
        .lane_1_rx_i              (lane_1_rx_i),
        .data_incoming            (data_incoming),
        .sbrx                     (sbrx),
        .sbtx                     (sbtx),
        .lane_0_tx_o              (lane_0_tx_o),
        .lane_1_tx_o              (lane_1_tx_o),
        .enable_scr               (enable_scr)
    );

    always #5 local_clk = ~local_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        c_address = a;
        c_data_in = d;
        c_write   = 1'b1;
        @(negedge local_clk);
        c_write   = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        c_address = a;
        c_read    = 1'b1;
        @(negedge local_clk);
        c_read    = 1'b0;
        d = c_data_out;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge local_clk);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        wait_neg(3);
        checks++;
        if (lane_0_tx_o !== 8'h00 || sbtx !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold lane0=%h sbtx=%b exp 00/0", lane_0_tx_o, sbtx);
        end
        rst = 1'b1;
        @(negedge local_clk);
        checks++;
        if ({lane_0_tx_o, lane_1_tx_o, transport_layer_data_out} !== 24'h0 ||
            {sbtx, enable_scr} !== 2'b00 || c_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs l0=%h l1=%h rx=%h sbtx=%b scr=%b cdo=%h exp all 0",
                     lane_0_tx_o, lane_1_tx_o, transport_layer_data_out,
                     sbtx, enable_scr, c_data_out);
        end
        cfg_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_status got %h exp 0", rd);
        end
    endtask

    task automatic test_config;
        logic [31:0] rd;
        cfg_write(8'h0C, 32'hDEADBEEF);
        cfg_read(8'h0C, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL scratch_rw got %h exp deadbeef", rd);
        end
        cfg_read(8'h20, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got %h exp 0", rd);
        end
        c_address = 8'h0C;
        c_data_in = 32'h12345678;
        c_write = 1'b1;
        c_read = 1'b1;
        @(negedge local_clk);
        c_write = 1'b0;
        c_read = 1'b0;
        checks++;
        if (c_data_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rw_same_cycle got %h exp deadbeef", c_data_out);
        end
        cfg_read(8'h0C, rd);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL scratch_new got %h exp 12345678", rd);
        end
        c_address = 8'h00;
        wait_neg(2);
        checks++;
        if (c_data_out !== 32'h12345678) begin
            errors++;
            $display("FAIL read_hold got %h exp 12345678", c_data_out);
        end
    endtask

    task automatic enter_training;
        sbrx = 1'b1;
        wait_neg(3);
        checks++;
        if (lane_0_tx_o !== 8'h00) begin
            errors++;
            $display("FAIL filter_early lane0=%h exp 00", lane_0_tx_o);
        end
        @(negedge local_clk);
        checks++;
        if (lane_0_tx_o !== 8'h4B || lane_1_tx_o !== 8'h4B || sbtx !== 1'b1) begin
            errors++;
            $display("FAIL training_lanes l0=%h l1=%h sbtx=%b exp 4b/4b/1",
                     lane_0_tx_o, lane_1_tx_o, sbtx);
        end
    endtask

    task automatic feed_ts(input int n);
        for (int i = 0; i < n; i++) begin
            data_incoming = 1'b1;
            lane_0_rx_i = 8'h4B;
            @(negedge local_clk);
        end
        data_incoming = 1'b0;
        lane_0_rx_i = 8'h00;
    endtask

    task automatic test_training;
        logic [31:0] rd;
        cfg_write(8'h00, 32'h1);
        checks++;
        if (sbtx !== 1'b1) begin
            errors++;
            $display("FAIL cld_sbtx got %b exp 1", sbtx);
        end
        enter_training();
        cfg_read(8'h04, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL status_training got %h exp 1", rd);
        end
        feed_ts(5);
        data_incoming = 1'b1;
        lane_0_rx_i = 8'h4C;
        @(negedge local_clk);
        feed_ts(7);
        checks++;
        if (lane_0_tx_o !== 8'h4B) begin
            errors++;
            $display("FAIL ts_restart lane0=%h exp 4b", lane_0_tx_o);
        end
        feed_ts(1);
        cfg_read(8'h04, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL status_cl0 got %h exp 2", rd);
        end
        cfg_read(8'h08, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rx_count_init got %h exp 0", rd);
        end
    endtask

    task automatic test_data;
        logic [31:0] rd;
        transport_layer_data_in = 8'hA5;
        @(negedge local_clk);
        checks++;
        if (lane_0_tx_o !== 8'hA5 || lane_1_tx_o !== 8'hA5) begin
            errors++;
            $display("FAIL tx_pass l0=%h l1=%h exp a5", lane_0_tx_o, lane_1_tx_o);
        end
        lane_0_rx_i = 8'h3C;
        data_incoming = 1'b1;
        @(negedge local_clk);
        data_incoming = 1'b0;
        lane_0_rx_i = 8'h77;
        checks++;
        if (transport_layer_data_out !== 8'h3C) begin
            errors++;
            $display("FAIL rx_pass got %h exp 3c", transport_layer_data_out);
        end
        @(negedge local_clk);
        checks++;
        if (transport_layer_data_out !== 8'h3C) begin
            errors++;
            $display("FAIL rx_hold got %h exp 3c", transport_layer_data_out);
        end
        cfg_read(8'h08, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL rx_count got %h exp 1", rd);
        end
        lane_0_rx_i = 8'h81;
        data_incoming = 1'b1;
        @(negedge local_clk);
        data_incoming = 1'b0;
        cfg_read(8'h08, rd);
        checks++;
        if (rd !== 32'h2 || transport_layer_data_out !== 8'h81) begin
            errors++;
            $display("FAIL rx_second cnt=%h rx=%h exp 2/81", rd, transport_layer_data_out);
        end
    endtask

    task automatic test_scr_mode;
        logic [31:0] rd;
        logic [7:0] exp_tx;
        logic       exp_scr;
`ifdef USB4_SCRAMBLER_EN
        exp_tx  = 8'h5A ^ 8'hFF;
        exp_scr = 1'b1;
`else
        exp_tx  = 8'h5A;
        exp_scr = 1'b0;
`endif
        transport_layer_data_in = 8'h5A;
        cfg_write(8'h00, 32'h3);
        checks++;
        if (enable_scr !== exp_scr) begin
            errors++;
            $display("FAIL enable_scr got %b exp %b", enable_scr, exp_scr);
        end
        @(negedge local_clk);
        checks++;
        if (lane_0_tx_o !== exp_tx) begin
            errors++;
            $display("FAIL scr_tx got %h exp %h", lane_0_tx_o, exp_tx);
        end
        cfg_read(8'h00, rd);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL ctrl_readback got %h exp 3", rd);
        end
        cfg_write(8'h00, 32'h1);
        transport_layer_data_in = 8'h00;
    endtask

    task automatic test_disable;
        logic [31:0] rd;
        lane_disable = 1'b1;
        @(negedge local_clk);
        checks++;
        if (lane_0_tx_o !== 8'h00 || lane_1_tx_o !== 8'h00 || sbtx !== 1'b0) begin
            errors++;
            $display("FAIL disable_out l0=%h l1=%h sbtx=%b exp 00/00/0",
                     lane_0_tx_o, lane_1_tx_o, sbtx);
        end
        cfg_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL disable_status got %h exp 0", rd);
        end
        sbrx = 1'b0;
        lane_disable = 1'b0;
        @(negedge local_clk);
    endtask

    task automatic test_exit_priority;
        logic [31:0] rd;
        enter_training();
        feed_ts(7);
        sbrx = 1'b0;
        feed_ts(1);
        cfg_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL exit_priority got %h exp 0", rd);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] rd;
        int cyc;
        enter_training();
        cyc = 0;
        while (lane_0_tx_o === 8'h4B && cyc < 2000) begin
            @(negedge local_clk);
            cyc++;
        end
        checks++;
        if (cyc !== 1024) begin
            errors++;
            $display("FAIL timeout_cycles got %0d exp 1024", cyc);
        end
        cfg_read(8'h04, rd);
        sbrx = 1'b0;
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL timeout_status got %h exp 4", rd);
        end
        cfg_write(8'h04, 32'h4);
        cfg_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL timeout_clear got %h exp 0", rd);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] rd;
        enter_training();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (lane_0_tx_o !== 8'h00 || sbtx !== 1'b0) begin
            errors++;
            $display("FAIL async_reset lane0=%h sbtx=%b exp 00/0", lane_0_tx_o, sbtx);
        end
        sbrx = 1'b0;
        @(negedge local_clk);
        rst = 1'b1;
        cfg_read(8'h00, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl got %h exp 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_training();
        test_data();
        test_scr_mode();
        test_disable();
        test_exit_priority();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
